// File: rtl/mac_drain_if.sv
// Stream bundle for mac_drain: tap/accumulator inputs from the MAC array,
// clear pulse back to it, result stream toward the feature-map writer, plus debug taps.
interface mac_drain_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             tap_valid;
    logic [15:0]      acc_in;
    logic             acc_clear;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic [7:0]       dbg_tap_cnt;
    logic             dbg_cap_pending;

    // Result stream: a transfer happens on every rising edge where out_valid && out_ready;
    // out_data holds steady while out_valid is high and out_ready is low.
    modport master (
        input  tap_valid, acc_in, out_ready,
        output acc_clear, out_data, out_valid, fifo_level, overflow,
        output dbg_tap_cnt, dbg_cap_pending
    );

    modport slave (
        output tap_valid, acc_in, out_ready,
        input  acc_clear, out_data, out_valid, fifo_level, overflow,
        input  dbg_tap_cnt, dbg_cap_pending
    );
endinterface

// File: rtl/mac_drain.sv
// fp16 MAC result drain: counts taps, captures/sanitises the accumulator per window, queues results.
// Optional ReLU on captured results is enabled by defining MAC_DRAIN_RELU_EN.
module mac_drain #(
    parameter int TAPS  = 9,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    mac_drain_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [7:0]       LAST_TAP = 8'(TAPS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [7:0]       tap_cnt_q, tap_cnt_d;
    logic             cap_pending_q, cap_pending_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level_q, level_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [15:0]      san;
    logic             out_valid;
    logic             pop;
    logic             push_ok;

    always_comb begin
        tap_cnt_d     = tap_cnt_q;
        cap_pending_d = 1'b0;
        if (bus.tap_valid) begin
            if (tap_cnt_q == LAST_TAP) begin
                tap_cnt_d     = 8'd0;
                cap_pending_d = 1'b1;
            end else begin
                tap_cnt_d = tap_cnt_q + 8'd1;
            end
        end
    end

    // Saturation and flush come first so ReLU sees the saturated sign.
    always_comb begin
        san = bus.acc_in;
        if (bus.acc_in[14:10] == 5'h1F) begin
            san = {bus.acc_in[15], 15'h7BFF};
        end else if (bus.acc_in[14:10] == 5'h00) begin
            san = 16'h0000;
        end
`ifdef MAC_DRAIN_RELU_EN
        if (san[15]) begin
            san = 16'h0000;
        end
`endif
    end

    assign out_valid = (level_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push_ok   = cap_pending_q && ((level_q != FULL_LVL) || pop);
    assign rd_next   = rd_ptr_q + PTR_W'(1);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q | (cap_pending_q && !push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = san;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Head register: load the incoming value when it becomes the head, else the next slot.
        if (level_q == '0) begin
            if (push_ok) begin
                out_data_d = san;
            end
        end else if (pop) begin
            if (level_q == LVL_W'(1)) begin
                if (push_ok) begin
                    out_data_d = san;
                end
            end else begin
                out_data_d = mem_q[rd_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt_q     <= 8'd0;
            cap_pending_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            out_data_q    <= 16'h0000;
            overflow_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            tap_cnt_q     <= tap_cnt_d;
            cap_pending_q <= cap_pending_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            out_data_q    <= out_data_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
        end
    end

    assign bus.acc_clear       = cap_pending_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = out_valid;
    assign bus.fifo_level      = level_q;
    assign bus.overflow        = overflow_q;
    assign bus.dbg_tap_cnt     = tap_cnt_q;
    assign bus.dbg_cap_pending = cap_pending_q;
endmodule

// File: tb/tb_mac_drain.sv
// Self-checking bench for mac_drain (TAPS=9, DEPTH=4) with a window-counting reference model.
module tb_mac_drain;
    localparam int TAPS  = 9;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    mac_drain_if #(.DEPTH(DEPTH)) bus ();

    mac_drain #(.TAPS(TAPS), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_pops  = 0;

    // Reference model: taps counted per window, results held as a plain queue.
    logic [15:0] exp_q[$];
    int   clr_q[$];
    int   m_taps        = 0;
    logic m_cap_pending = 1'b0;
    logic m_overflow    = 1'b0;

    function automatic logic [15:0] ref_san(input logic [15:0] v);
        int          e;
        logic [15:0] r;
        e = int'(v[14:10]);
        if (e == 31)     r = v[15] ? 16'hFBFF : 16'h7BFF;
        else if (e == 0) r = 16'h0000;
        else             r = v;
`ifdef MAC_DRAIN_RELU_EN
        if (r[15]) r = 16'h0000;
`endif
        return r;
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       v[14:10] = 5'h1F;
            1:       v[14:10] = 5'h00;
            default: ;
        endcase
        return v;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        clr_q.delete();
        m_taps        = 0;
        m_cap_pending = 1'b0;
        m_overflow    = 1'b0;
    endfunction

    // One clock: drive inputs, advance the model, check popped data, sample #1 after the edge.
    task automatic drive_cycle(input logic tv, input logic [15:0] acc, input logic rdy);
        logic m_pop;
        bus.tap_valid = tv;
        bus.acc_in    = acc;
        bus.out_ready = rdy;
        m_pop = rdy && (exp_q.size() > 0);
        if (m_pop) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pop_data cyc=%0d got valid=%b data=%h want %h", cyc, bus.out_valid, bus.out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_pops++;
        end
        if (m_cap_pending) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ref_san(acc));
            else m_overflow = 1'b1;
        end
        m_cap_pending = tv && ((m_taps + 1) % TAPS == 0);
        if (tv) m_taps = (m_taps + 1) % TAPS;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.acc_clear === 1'b1) clr_q.push_back(cyc);
    endtask

    task automatic run_window(input logic [15:0] cap_val, input logic rdy_taps, input logic rdy_cap);
        for (int i = 0; i < TAPS; i++) drive_cycle(1'b1, rand_fp(), rdy_taps);
        drive_cycle(1'b0, cap_val, rdy_cap);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.tap_valid = 1'b0;
        bus.acc_in    = 16'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        run_window(16'h4000, 1'b0, 1'b0);
        run_window(16'h4400, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, rand_fp(), 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd2 || bus.dbg_tap_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL pre_reset level=%0d tap_cnt=%0d want 2/5", bus.fifo_level, bus.dbg_tap_cnt);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.out_data !== 16'h0 ||
            bus.overflow !== 1'b0 || bus.acc_clear !== 1'b0 || bus.dbg_tap_cnt !== 8'd0 ||
            bus.dbg_cap_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset valid=%b level=%0d data=%h ovf=%b clr=%b tap=%0d want all zero",
                     bus.out_valid, bus.fifo_level, bus.out_data, bus.overflow, bus.acc_clear, bus.dbg_tap_cnt);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        run_window(16'h3555, 1'b0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd1 || bus.out_data !== 16'h3555) begin
            n_fail++;
            $display("FAIL post_reset_window level=%0d data=%h want 1/3555", bus.fifo_level, bus.out_data);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        for (int i = 0; i < TAPS; i++) drive_cycle(1'b1, rand_fp(), 1'b0);
        n_tests++;
        if (bus.acc_clear !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_e0 clr=%b valid=%b want 1/0", bus.acc_clear, bus.out_valid);
        end
        drive_cycle(1'b0, 16'h3C00, 1'b0);
        n_tests++;
        if (bus.acc_clear !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h3C00) begin
            n_fail++;
            $display("FAIL basic_e1 clr=%b valid=%b data=%h want 0/1/3c00", bus.acc_clear, bus.out_valid, bus.out_data);
        end
        drive_cycle(1'b0, 16'h0, 1'b0);
        n_tests++;
        if (bus.out_data !== 16'h3C00 || bus.out_valid !== 1'b1 || clr_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_hold data=%h valid=%b clr_pulses=%0d want 3c00/1/1", bus.out_data, bus.out_valid, clr_q.size());
        end
    endtask

    task automatic test_sanitise();
        logic [15:0] want [3];
`ifdef MAC_DRAIN_RELU_EN
        want[0] = 16'h0000; want[1] = 16'h0000; want[2] = 16'h0000;
`else
        want[0] = 16'hFBFF; want[1] = 16'h0000; want[2] = 16'hC000;
`endif
        apply_reset();
        run_window(16'hFC01, 1'b0, 1'b0);
        run_window(16'h0123, 1'b0, 1'b0);
        run_window(16'hC000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want[i]) begin
                n_fail++;
                $display("FAIL sanitise_%0d valid=%b data=%h want %h", i, bus.out_valid, bus.out_data, want[i]);
            end
            drive_cycle(1'b0, 16'h0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int pops0;
        apply_reset();
        pops0 = n_pops;
        for (int i = 0; i < 4 * TAPS; i++) drive_cycle(1'b1, rand_fp(), 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, rand_fp(), 1'b1);
        n_tests++;
        if (n_pops - pops0 != 4 || bus.overflow !== 1'b0 || bus.fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_count results=%0d ovf=%b level=%0d want 4/0/0", n_pops - pops0, bus.overflow, bus.fifo_level);
        end
        n_tests++;
        if (clr_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_clears got %0d pulses want 4", clr_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_tests++;
                if (clr_q[i] - clr_q[i-1] != TAPS) begin
                    n_fail++;
                    $display("FAIL b2b_spacing gap=%0d want %0d", clr_q[i] - clr_q[i-1], TAPS);
                end
            end
        end
    endtask

    task automatic test_overflow_wrap();
        int pops0;
        apply_reset();
        for (int w = 0; w < 5; w++) run_window(rand_fp(), 1'b0, 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full level=%0d ovf=%b want 4/1", bus.fifo_level, bus.overflow);
        end
        pops0 = n_pops;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive_cycle(1'b0, 16'h0, 1'b1);
        n_tests++;
        if (n_pops - pops0 != 4 || bus.fifo_level !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain pops=%0d level=%0d valid=%b want 4/0/0", n_pops - pops0, bus.fifo_level, bus.out_valid);
        end
        pops0 = n_pops;
        for (int w = 0; w < 6; w++) run_window(rand_fp(), 1'b1, 1'b1);
        drive_cycle(1'b0, 16'h0, 1'b1);
        n_tests++;
        if (n_pops - pops0 != 6 || bus.overflow !== 1'b1 || bus.fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_run pops=%0d ovf=%b level=%0d want 6/1/0", n_pops - pops0, bus.overflow, bus.fifo_level);
        end
    endtask

    task automatic test_full_pop();
        int pops0;
        apply_reset();
        for (int w = 0; w < 4; w++) run_window(rand_fp(), 1'b0, 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_fill level=%0d ovf=%b want 4/0", bus.fifo_level, bus.overflow);
        end
        pops0 = n_pops;
        run_window(rand_fp(), 1'b0, 1'b1);
        n_tests++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0 || n_pops - pops0 != 1) begin
            n_fail++;
            $display("FAIL fullpop_edge level=%0d ovf=%b pops=%0d want 4/0/1", bus.fifo_level, bus.overflow, n_pops - pops0);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive_cycle(1'b0, 16'h0, 1'b1);
        n_tests++;
        if (bus.fifo_level !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fullpop_drain level=%0d left=%0d want 0/0", bus.fifo_level, exp_q.size());
        end
    endtask

    task automatic test_random();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_fp(), 1'($urandom_range(0, 1)));
            if (bus.fifo_level !== 3'(exp_q.size()) || bus.overflow !== m_overflow ||
                bus.acc_clear !== m_cap_pending || bus.out_valid !== (exp_q.size() > 0)) begin
                if (bad < 5)
                    $display("FAIL random_state cyc=%0d level=%0d ovf=%b clr=%b want %0d/%b/%b",
                             cyc, bus.fifo_level, bus.overflow, bus.acc_clear, exp_q.size(), m_overflow, m_cap_pending);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        for (int i = 0; i < 12 && (exp_q.size() > 0 || m_cap_pending); i++) drive_cycle(1'b0, rand_fp(), 1'b1);
        n_tests++;
        if (bus.fifo_level !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain level=%0d left=%0d want 0/0", bus.fifo_level, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.tap_valid = 1'b0;
        bus.acc_in    = 16'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sanitise();
        test_back_to_back();
        test_overflow_wrap();
        test_full_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
